// File: rtl/noc_perf_counter_bank_if.sv
// Read port of the router performance-counter bank.
// The master side (debug/CSR logic) issues an index request and accepts the
// shadow value. The slave side (the counter bank) answers one cycle later.
interface noc_perf_counter_bank_if #(
   parameter int NUM_EVT = 10,
   parameter int CNT_W   = 32
);
   localparam int IDX_W = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;

   logic             rd_req_vld;
   logic             rd_req_rdy;
   logic [IDX_W-1:0] rd_idx;
   logic             rd_rsp_vld;
   logic             rd_rsp_rdy;
   logic [CNT_W-1:0] rd_rsp_data;

   modport master (
      output rd_req_vld,
      output rd_idx,
      output rd_rsp_rdy,
      input  rd_req_rdy,
      input  rd_rsp_vld,
      input  rd_rsp_data
   );

   modport slave (
      input  rd_req_vld,
      input  rd_idx,
      input  rd_rsp_rdy,
      output rd_req_rdy,
      output rd_rsp_vld,
      output rd_rsp_data
   );
endinterface

// File: rtl/noc_perf_counter_bank.sv
// Router performance-counter bank.
// Counts NUM_EVT event strobes over a programmable window. At each window
// end the live counts are copied into shadow registers and the live counts
// restart from zero. Shadow values are read one at a time via the read
// interface with a fixed one-cycle response latency.
// Build option: define NOC_PERF_MON_SAT_EN to make live counters saturate
// instead of wrapping. In both modes ovf_o flags the overflowing increment.
module noc_perf_counter_bank #(
   parameter int NUM_EVT = 10,
   parameter int CNT_W   = 32,
   parameter int WIN_W   = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 enable_i,
   input  logic                 clear_i,
   input  logic [WIN_W-1:0]     win_len_i,
   input  logic [NUM_EVT-1:0]   evt_i,
   output logic                 snap_o,
   output logic [NUM_EVT-1:0]   ovf_o,
   noc_perf_counter_bank_if.slave rd
);

   localparam int IDX_W = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } mode_e;

   mode_e mode;

   logic [CNT_W-1:0] live_q   [NUM_EVT];
   logic [CNT_W-1:0] live_d   [NUM_EVT];
   logic [CNT_W-1:0] shadow_q [NUM_EVT];
   logic [CNT_W-1:0] shadow_d [NUM_EVT];
   logic [CNT_W-1:0] live_inc [NUM_EVT];
   logic [NUM_EVT-1:0] ovf_hit;
   logic [NUM_EVT-1:0] ovf_q, ovf_d;
   logic [WIN_W-1:0] timer_q, timer_d;
   logic             snap_q, snap_d;
   logic             win_end;

   logic             rsp_vld_q, rsp_vld_d;
   logic [CNT_W-1:0] rsp_data_q, rsp_data_d;
   logic [CNT_W-1:0] rd_sel;
   logic             rd_accept;

   // Counting is active only while enabled; otherwise everything holds.
   always_comb begin
      mode = enable_i ? COUNT : IDLE;
   end

   // Per-counter next value for this cycle's event, with wrap or saturation.
   always_comb begin
      ovf_hit = '0;
      for (int k = 0; k < NUM_EVT; k++) begin
         live_inc[k] = live_q[k];
         if (evt_i[k]) begin
            if (live_q[k] == CNT_MAX) begin
               ovf_hit[k] = 1'b1;
`ifdef NOC_PERF_MON_SAT_EN
               live_inc[k] = live_q[k];
`else
               live_inc[k] = '0;
`endif
            end else begin
               live_inc[k] = live_q[k] + CNT_W'(1);
            end
         end
      end
   end

   // A window closes when the timer reaches the last cycle of the programmed length.
   always_comb begin
      win_end = (mode == COUNT) && (win_len_i != '0) &&
                (timer_q == (win_len_i - WIN_W'(1)));
   end

   // Live/shadow/timer/overflow update; clear overrides window end and enable.
   always_comb begin
      live_d   = live_q;
      shadow_d = shadow_q;
      timer_d  = timer_q;
      ovf_d    = ovf_q;
      snap_d   = 1'b0;
      if (clear_i) begin
         for (int k = 0; k < NUM_EVT; k++) begin
            live_d[k]   = '0;
            shadow_d[k] = '0;
         end
         timer_d = '0;
         ovf_d   = '0;
      end else if (mode == COUNT) begin
         ovf_d = ovf_q | ovf_hit;
         if (win_end) begin
            for (int k = 0; k < NUM_EVT; k++) begin
               shadow_d[k] = live_inc[k];
               live_d[k]   = '0;
            end
            timer_d = '0;
            snap_d  = 1'b1;
         end else begin
            live_d  = live_inc;
            timer_d = (win_len_i == '0) ? '0 : timer_q + WIN_W'(1);
         end
      end
   end

   // Shadow selection for a read; indices beyond the bank return zero.
   always_comb begin
      rd_sel = '0;
      for (int k = 0; k < NUM_EVT; k++) begin
         if (rd.rd_idx == IDX_W'(k)) begin
            rd_sel = shadow_q[k];
         end
      end
   end

   assign rd.rd_req_rdy = !rsp_vld_q || rd.rd_rsp_rdy;
   assign rd_accept     = rd.rd_req_vld && rd.rd_req_rdy;

   // Response register: load on accept, drop when consumed, otherwise hold.
   always_comb begin
      rsp_vld_d  = rsp_vld_q;
      rsp_data_d = rsp_data_q;
      if (rd_accept) begin
         rsp_vld_d  = 1'b1;
         rsp_data_d = rd_sel;
      end else if (rd.rd_rsp_rdy) begin
         rsp_vld_d  = 1'b0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < NUM_EVT; k++) begin
            live_q[k]   <= '0;
            shadow_q[k] <= '0;
         end
         timer_q    <= '0;
         ovf_q      <= '0;
         snap_q     <= 1'b0;
         rsp_vld_q  <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         live_q     <= live_d;
         shadow_q   <= shadow_d;
         timer_q    <= timer_d;
         ovf_q      <= ovf_d;
         snap_q     <= snap_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   assign snap_o         = snap_q;
   assign ovf_o          = ovf_q;
   assign rd.rd_rsp_vld  = rsp_vld_q;
   assign rd.rd_rsp_data = rsp_data_q;

endmodule

// File: tb/tb_noc_perf_counter_bank.sv
// Testbench for noc_perf_counter_bank.
// Uses a small configuration (4-bit counters, 6-bit window) so that counter
// overflow and timer wrap occur within short runs. A behavioural model of
// counts, windows and the read port is compared against the outputs every
// cycle; directed scenarios add hand-computed expectations.
// Honours NOC_PERF_MON_SAT_EN for the overflow behaviour.
module tb_noc_perf_counter_bank;

   localparam int NUM_EVT = 10;
   localparam int CNT_W   = 4;
   localparam int WIN_W   = 6;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int WIN_MOD = 1 << WIN_W;
`ifdef NOC_PERF_MON_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic               enable = 1'b0;
   logic               clear = 1'b0;
   logic [WIN_W-1:0]   win_len = '0;
   logic [NUM_EVT-1:0] evt = '0;
   logic               snap;
   logic [NUM_EVT-1:0] ovf;

   noc_perf_counter_bank_if #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W)) rd_bus ();

   noc_perf_counter_bank #(
      .NUM_EVT (NUM_EVT),
      .CNT_W   (CNT_W),
      .WIN_W   (WIN_W)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .enable_i  (enable),
      .clear_i   (clear),
      .win_len_i (win_len),
      .evt_i     (evt),
      .snap_o    (snap),
      .ovf_o     (ovf),
      .rd        (rd_bus)
   );

   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;
   bit check_en  = 1'b0;

   // Behavioural model state
   int m_live   [NUM_EVT];
   int m_shadow [NUM_EVT];
   int m_timer;
   int m_ovf;
   bit m_snap;
   bit m_rsp_vld;
   int m_rsp_data;

   task automatic check_value(input string name, input int actual, input int expected);
      total_cnt++;
      if (actual == expected) pass_cnt++;
      else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
   endtask

   // Model: advance one cycle from the spec's rules, or reset at once.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < NUM_EVT; k++) begin
            m_live[k]   = 0;
            m_shadow[k] = 0;
         end
         m_timer = 0; m_ovf = 0; m_snap = 0; m_rsp_vld = 0; m_rsp_data = 0;
      end else begin
         int sum [NUM_EVT];
         int win;
         int idx;
         bit accept;
         win    = int'(win_len);
         idx    = int'(rd_bus.rd_idx);
         accept = rd_bus.rd_req_vld && (!m_rsp_vld || rd_bus.rd_rsp_rdy);
         if (accept) begin
            m_rsp_vld  = 1;
            m_rsp_data = (idx < NUM_EVT) ? m_shadow[idx] : 0;
         end else if (rd_bus.rd_rsp_rdy) begin
            m_rsp_vld = 0;
         end
         m_snap = 0;
         if (clear) begin
            for (int k = 0; k < NUM_EVT; k++) begin
               m_live[k]   = 0;
               m_shadow[k] = 0;
            end
            m_timer = 0;
            m_ovf   = 0;
         end else if (enable) begin
            for (int k = 0; k < NUM_EVT; k++) begin
               sum[k] = m_live[k] + int'(evt[k]);
               if (sum[k] > CNT_MAX) begin
                  m_ovf  = m_ovf | (1 << k);
                  sum[k] = SAT ? CNT_MAX : sum[k] % (CNT_MAX + 1);
               end
            end
            if (win != 0 && m_timer == win - 1) begin
               for (int k = 0; k < NUM_EVT; k++) begin
                  m_shadow[k] = sum[k];
                  m_live[k]   = 0;
               end
               m_timer = 0;
               m_snap  = 1;
            end else begin
               for (int k = 0; k < NUM_EVT; k++) m_live[k] = sum[k];
               m_timer = (win == 0) ? 0 : (m_timer + 1) % WIN_MOD;
            end
         end
      end
   end

   task automatic check_output();
      check_value("snap_o", int'(snap), int'(m_snap));
      check_value("ovf_o", int'(ovf), m_ovf);
      check_value("rd_req_rdy", int'(rd_bus.rd_req_rdy), int'(!m_rsp_vld || rd_bus.rd_rsp_rdy));
      check_value("rd_rsp_vld", int'(rd_bus.rd_rsp_vld), int'(m_rsp_vld));
      if (m_rsp_vld) check_value("rd_rsp_data", int'(rd_bus.rd_rsp_data), m_rsp_data);
   endtask

   // Continuous compare against the model, mid-cycle.
   always @(negedge clk) begin
      if (check_en) check_output();
   end

   // Drive one cycle of inputs, then step just past the next rising edge.
   task automatic apply_stimulus(input bit en, input bit clr, input int win,
                                 input logic [NUM_EVT-1:0] ev, input bit rv,
                                 input int idx, input bit rr);
      enable            = en;
      clear             = clr;
      win_len           = win[WIN_W-1:0];
      evt               = ev;
      rd_bus.rd_req_vld = rv;
      rd_bus.rd_idx     = idx[3:0];
      rd_bus.rd_rsp_rdy = rr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_read(input int idx, input int expected, input string name);
      apply_stimulus(0, 0, 0, '0, 1, idx, 1);
      check_value(name, int'(rd_bus.rd_rsp_data), expected);
   endtask

   int exp3;
   int cur_win;

   initial begin
      rd_bus.rd_req_vld = 1'b0;
      rd_bus.rd_idx     = '0;
      rd_bus.rd_rsp_rdy = 1'b1;
      exp3 = SAT ? 15 : 1;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check_en = 1'b1;
      check_value("reset snap_o", int'(snap), 0);
      check_value("reset ovf_o", int'(ovf), 0);
      check_value("reset rd_req_rdy", int'(rd_bus.rd_req_rdy), 1);
      check_value("reset rd_rsp_vld", int'(rd_bus.rd_rsp_vld), 0);
      check_value("reset rd_rsp_data", int'(rd_bus.rd_rsp_data), 0);
      rstn = 1'b1;

      // Scenario 1: window of 8, evt[0] every cycle
      for (int i = 0; i < 16; i++) apply_stimulus(1, 0, 8, 10'b1, 0, 0, 1);
      idle_read(0, 8, "win8 shadow[0]");
      idle_read(1, 0, "win8 shadow[1]");

      // Scenario 2: event only in the window-end cycle
      apply_stimulus(1, 1, 4, '0, 0, 0, 1);
      for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 4, '0, 0, 0, 1);
      apply_stimulus(1, 0, 4, 10'b100, 0, 0, 1);
      idle_read(2, 1, "end-cycle evt shadow[2]");
      for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 4, '0, 0, 0, 1);
      idle_read(2, 0, "live[2] restarted");

      // Scenario 3: free-run, evt[3] for 17 cycles
      apply_stimulus(1, 1, 0, '0, 0, 0, 1);
      for (int i = 0; i < 17; i++) apply_stimulus(1, 0, 0, 10'b1000, 0, 0, 1);
      check_value("ovf_o[3] after 17", int'(ovf[3]), 1);
      check_value("ovf_o others", int'(ovf & ~10'b1000), 0);
      apply_stimulus(1, 0, 1, '0, 0, 0, 1);
      idle_read(3, exp3, "live[3] after 17");

      // Scenario 4: response back-pressure then back-to-back reads
      apply_stimulus(0, 0, 0, '0, 1, 3, 0);
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(0, 0, 0, '0, 1, 0, 0);
         check_value("stall rd_req_rdy", int'(rd_bus.rd_req_rdy), 0);
         check_value("stall rd_rsp_vld", int'(rd_bus.rd_rsp_vld), 1);
         check_value("stall rd_rsp_data", int'(rd_bus.rd_rsp_data), exp3);
      end
      apply_stimulus(0, 0, 0, '0, 1, 3, 1);
      check_value("b2b data idx3", int'(rd_bus.rd_rsp_data), exp3);
      apply_stimulus(0, 0, 0, '0, 1, 0, 1);
      check_value("b2b data idx0", int'(rd_bus.rd_rsp_data), 0);
      check_value("b2b vld", int'(rd_bus.rd_rsp_vld), 1);
      apply_stimulus(0, 0, 0, '0, 1, 3, 1);
      check_value("b2b data idx3 again", int'(rd_bus.rd_rsp_data), exp3);
      apply_stimulus(0, 0, 0, '0, 1, 12, 1);
      check_value("idx12 data", int'(rd_bus.rd_rsp_data), 0);
      apply_stimulus(0, 0, 0, '0, 0, 0, 1);
      check_value("drained rd_rsp_vld", int'(rd_bus.rd_rsp_vld), 0);

      // Scenario 5a: clear in the window-end cycle
      apply_stimulus(1, 1, 8, '0, 0, 0, 1);
      for (int i = 0; i < 7; i++) apply_stimulus(1, 0, 8, '1, 0, 0, 1);
      apply_stimulus(1, 1, 8, '1, 0, 0, 1);
      check_value("clear at end snap_o", int'(snap), 0);
      idle_read(0, 0, "clear at end shadow[0]");

      // Scenario 5b: enable dropped for 5 cycles delays the snapshot by 5
      apply_stimulus(1, 1, 8, '0, 0, 0, 1);
      for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 8, 10'b1, 0, 0, 1);
      for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 8, 10'b1, 0, 0, 1);
      for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 8, 10'b1, 0, 0, 1);
      check_value("paused snap not yet", int'(snap), 0);
      apply_stimulus(1, 0, 8, 10'b1, 0, 0, 1);
      check_value("paused snap now", int'(snap), 1);
      idle_read(0, 8, "paused shadow[0]");

      // Scenario 6: reset while a response is pending
      for (int i = 0; i < 2; i++) apply_stimulus(1, 0, 2, '1, 0, 0, 1);
      apply_stimulus(0, 0, 0, '0, 1, 5, 0);
      check_value("pre-reset data", int'(rd_bus.rd_rsp_data), 2);
      apply_stimulus(1, 0, 0, '1, 0, 0, 0);
      rstn = 1'b0;
      #1;
      check_value("mid reset snap_o", int'(snap), 0);
      check_value("mid reset ovf_o", int'(ovf), 0);
      check_value("mid reset rd_rsp_vld", int'(rd_bus.rd_rsp_vld), 0);
      check_value("mid reset rd_rsp_data", int'(rd_bus.rd_rsp_data), 0);
      check_value("mid reset rd_req_rdy", int'(rd_bus.rd_req_rdy), 1);
      apply_stimulus(0, 0, 0, '0, 0, 0, 1);
      apply_stimulus(0, 0, 0, '0, 0, 0, 1);
      rstn = 1'b1;
      idle_read(5, 0, "post-reset shadow[5]");

      // Randomized phase against the model
      cur_win = 8;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            case ($urandom_range(0, 8))
               0: cur_win = 0;
               1: cur_win = 1;
               2: cur_win = 2;
               3: cur_win = 3;
               4: cur_win = 5;
               5: cur_win = 8;
               6: cur_win = 13;
               7: cur_win = 40;
               default: cur_win = 63;
            endcase
         end
         apply_stimulus($urandom_range(0, 7) != 0, $urandom_range(0, 63) == 0, cur_win,
                        NUM_EVT'($urandom), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
      end

      check_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
